// File: rtl/stim_train_gen.sv
// Stimulation pulse-train generator: turns a one-cycle stim request into a
// delayed train of programmable pulses followed by a refractory hold-off.
module stim_train_gen #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
) (
  input  logic             sample_CLK_out,
  input  logic             reset,
  input  logic             enable,
  input  logic             stim_req,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic [CNT_W-1:0] period_cfg,
  input  logic [NP_W-1:0]  npulse_cfg,
  input  logic [CNT_W-1:0] refract_cfg,
  output logic             stim_out,
  output logic             blank_out,
  output logic             busy,
  output logic [NP_W-1:0]  pulse_count,
  output logic [15:0]      missed_count,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_HIGH    = 3'd2,
    ST_LOW     = 3'd3,
    ST_REFRACT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NP_W-1:0]  NP_ZERO  = NP_W'(0);
  localparam logic [NP_W-1:0]  NP_ONE   = NP_W'(1);
  localparam logic [15:0]      MISS_MAX = 16'hFFFF;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_m1_q, w_m1_d;
  logic [CNT_W-1:0] low_m1_q, low_m1_d;
  logic [CNT_W-1:0] refract_q, refract_d;
  logic [NP_W-1:0]  npulse_q, npulse_d;
  logic [NP_W-1:0]  pcnt_q, pcnt_d;
  logic [15:0]      missed_q, missed_d;
  logic             stim_q, blank_q, busy_q;
  logic [CNT_W-1:0] w_eff_s, low_m1_s;

  // Width 0 acts as 1; the low phase is stored minus one so period <= width
  // clamps to period = width+1 without needing a wider adder.
  always_comb begin
    w_eff_s = (width_cfg == CNT_ZERO) ? CNT_ONE : width_cfg;
    if (period_cfg > w_eff_s) begin
      low_m1_s = period_cfg - w_eff_s - CNT_ONE;
    end else begin
      low_m1_s = CNT_ZERO;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_m1_d    = w_m1_q;
    low_m1_d  = low_m1_q;
    refract_d = refract_q;
    npulse_d  = npulse_q;
    pcnt_d    = pcnt_q;
    missed_d  = missed_q;
    if (enable) begin
      if (stim_req && (state_q != ST_IDLE) && (missed_q != MISS_MAX)) begin
        missed_d = missed_q + 16'd1;
      end else begin
        missed_d = missed_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (stim_req && (npulse_cfg != NP_ZERO)) begin
            w_m1_d    = w_eff_s - CNT_ONE;
            low_m1_d  = low_m1_s;
            refract_d = refract_cfg;
            npulse_d  = npulse_cfg;
            if (delay_cfg != CNT_ZERO) begin
              state_d = ST_DELAY;
              cnt_d   = delay_cfg - CNT_ONE;
              pcnt_d  = NP_ZERO;
            end else begin
              state_d = ST_HIGH;
              cnt_d   = w_eff_s - CNT_ONE;
              pcnt_d  = NP_ONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY, ST_LOW: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_HIGH;
            cnt_d   = w_m1_q;
            pcnt_d  = pcnt_q + NP_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (pcnt_q != npulse_q) begin
            state_d = ST_LOW;
            cnt_d   = low_m1_q;
          end else if (refract_q != CNT_ZERO) begin
            state_d = ST_REFRACT;
            cnt_d   = refract_q - CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end
        ST_REFRACT: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end
  end

  // Outputs are registered from the next state so they line up with state_out.
  always_ff @(posedge sample_CLK_out) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      w_m1_q    <= CNT_ZERO;
      low_m1_q  <= CNT_ZERO;
      refract_q <= CNT_ZERO;
      npulse_q  <= NP_ZERO;
      pcnt_q    <= NP_ZERO;
      missed_q  <= 16'd0;
      stim_q    <= 1'b0;
      blank_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_m1_q    <= w_m1_d;
      low_m1_q  <= low_m1_d;
      refract_q <= refract_d;
      npulse_q  <= npulse_d;
      pcnt_q    <= pcnt_d;
      missed_q  <= missed_d;
      stim_q    <= (state_d == ST_HIGH);
      blank_q   <= (state_d != ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign stim_out     = stim_q;
  assign blank_out    = blank_q;
  assign busy         = busy_q;
  assign pulse_count  = pcnt_q;
  assign missed_count = missed_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_stim_train_gen.sv
// Self-checking bench for stim_train_gen: directed scenarios plus random traffic,
// compared each cycle against a timing-formula reference model.
module tb_stim_train_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        stim_req = 1'b0;
  logic [15:0] delay_cfg = 16'd0;
  logic [15:0] width_cfg = 16'd0;
  logic [15:0] period_cfg = 16'd0;
  logic [7:0]  npulse_cfg = 8'd0;
  logic [15:0] refract_cfg = 16'd0;
  logic        stim_out, blank_out, busy;
  logic [7:0]  pulse_count;
  logic [15:0] missed_count;
  logic [2:0]  state_out;

  int n_checks = 0;
  int n_fail = 0;
  int t = 0;
  logic [29:0] obs, exp_v;

  // Reference model: one active train described by its acceptance edge and latched values.
  bit m_active = 1'b0;
  int m_N = 0, m_D = 0, m_W = 1, m_P = 2, m_K = 0, m_R = 0, m_end = 0;
  int m_pchold = 0;
  int m_missed = 0;

  stim_train_gen #(.CNT_W(16), .NP_W(8)) dut (
    .sample_CLK_out(clk),
    .reset(reset),
    .enable(enable),
    .stim_req(stim_req),
    .delay_cfg(delay_cfg),
    .width_cfg(width_cfg),
    .period_cfg(period_cfg),
    .npulse_cfg(npulse_cfg),
    .refract_cfg(refract_cfg),
    .stim_out(stim_out),
    .blank_out(blank_out),
    .busy(busy),
    .pulse_count(pulse_count),
    .missed_count(missed_count),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  function automatic int pc_at(int tt);
    int k;
    if (tt < m_N + m_D) return 0;
    k = (tt - m_N - m_D) / m_P + 1;
    return (k > m_K) ? m_K : k;
  endfunction

  function automatic logic [29:0] model_vec();
    logic s, b;
    logic [2:0] st;
    int pc, rel;
    s = 1'b0; b = 1'b0; st = 3'd0; pc = m_pchold;
    if (m_active) begin
      pc = pc_at(t);
      if (t < m_end) begin
        b = 1'b1;
        rel = t - m_N - m_D;
        if (rel < 0) st = 3'd1;
        else if ((rel / m_P) < m_K && (rel % m_P) < m_W) begin st = 3'd2; s = 1'b1; end
        else if ((rel / m_P) < m_K - 1) st = 3'd3;
        else st = 3'd4;
      end
    end
    return {s, b, b, st, 8'(pc), 16'(m_missed)};
  endfunction

  task automatic tick();
    @(posedge clk);
    t = t + 1;
    if (m_active && (t - 1) >= m_end) begin m_active = 1'b0; m_pchold = m_K; end
    if (reset) begin
      m_active = 1'b0; m_pchold = 0; m_missed = 0;
    end else if (!enable) begin
      if (m_active) begin m_pchold = pc_at(t - 1); m_active = 1'b0; end
    end else if (stim_req) begin
      if (m_active) begin
        if (m_missed < 65535) m_missed = m_missed + 1;
      end else if (npulse_cfg != 8'd0) begin
        m_active = 1'b1;
        m_N = t;
        m_D = int'(delay_cfg);
        m_W = (width_cfg == 16'd0) ? 1 : int'(width_cfg);
        m_P = int'(period_cfg);
        if (m_P < m_W + 1) m_P = m_W + 1;
        m_K = int'(npulse_cfg);
        m_R = int'(refract_cfg);
        m_end = m_N + m_D + (m_K - 1) * m_P + m_W + m_R;
      end
    end
    #1;
  endtask

  task automatic set_cfg(int d, int w, int p, int k, int r);
    delay_cfg = 16'(d); width_cfg = 16'(w); period_cfg = 16'(p);
    npulse_cfg = 8'(k); refract_cfg = 16'(r);
  endtask

  task automatic do_reset();
    stim_req = 1'b0; enable = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_cfg(3, 2, 5, 2, 1);
    stim_req = 1'b1; reset = 1'b1;
    tick(); tick();
    n_checks++;
    if ({stim_out, blank_out, busy, state_out, pulse_count, missed_count} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_values got=%h expected=0", {stim_out, blank_out, busy, state_out, pulse_count, missed_count});
    end
    reset = 1'b0; stim_req = 1'b0;
  endtask

  task automatic test_basic_train();
    logic e;
    do_reset();
    set_cfg(0, 2, 5, 3, 0);
    for (int i = 0; i < 26; i++) begin
      stim_req = (i == 10);
      tick();
      obs = {stim_out, blank_out, busy, state_out, pulse_count, missed_count};
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL basic_model t=%0d got=%h expected=%h", i, obs, exp_v); end
      e = (i inside {10, 11, 15, 16, 20, 21});
      n_checks++;
      if (stim_out !== e) begin n_fail++; $display("FAIL basic_stim t=%0d got=%b expected=%b", i, stim_out, e); end
      if (i == 21 || i == 22) begin
        n_checks++;
        if (busy !== (i == 21)) begin n_fail++; $display("FAIL basic_busy_fall t=%0d got=%b", i, busy); end
      end
    end
    stim_req = 1'b0;
    n_checks++;
    if (pulse_count !== 8'd3) begin n_fail++; $display("FAIL basic_pulse_count got=%0d expected=3", pulse_count); end
  endtask

  task automatic test_clamp_missed();
    logic e;
    do_reset();
    set_cfg(4, 1, 1, 2, 3);
    for (int i = 0; i < 24; i++) begin
      stim_req = (i inside {0, 2, 5, 10, 11});
      tick();
      obs = {stim_out, blank_out, busy, state_out, pulse_count, missed_count};
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL clamp_model t=%0d got=%h expected=%h", i, obs, exp_v); end
      if (i < 12) begin
        e = (i inside {4, 6});
        n_checks++;
        if (stim_out !== e) begin n_fail++; $display("FAIL clamp_stim t=%0d got=%b expected=%b", i, stim_out, e); end
        e = (i <= 9) || (i == 11);
        n_checks++;
        if (blank_out !== e) begin n_fail++; $display("FAIL clamp_blank t=%0d got=%b expected=%b", i, blank_out, e); end
      end
      if (i == 9) begin
        n_checks++;
        if (missed_count !== 16'd2) begin n_fail++; $display("FAIL missed_during_train got=%0d expected=2", missed_count); end
      end
      if (i == 10) begin
        n_checks++;
        if (missed_count !== 16'd3) begin n_fail++; $display("FAIL missed_at_end_edge got=%0d expected=3", missed_count); end
      end
    end
    stim_req = 1'b0;
  endtask

  task automatic test_cfg_change();
    logic e;
    do_reset();
    set_cfg(2, 3, 6, 3, 2);
    for (int i = 0; i < 56; i++) begin
      stim_req = (i == 0) || (i == 22);
      if (i == 4) begin
        width_cfg = 16'($urandom_range(1, 5));
        period_cfg = 16'($urandom_range(0, 9));
      end
      tick();
      obs = {stim_out, blank_out, busy, state_out, pulse_count, missed_count};
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL cfg_change_model t=%0d got=%h expected=%h", i, obs, exp_v); end
      if (i < 19) begin
        e = (i inside {[2:4], [8:10], [14:16]});
        n_checks++;
        if (stim_out !== e) begin n_fail++; $display("FAIL cfg_latched_stim t=%0d got=%b expected=%b", i, stim_out, e); end
      end
    end
    stim_req = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    set_cfg(1, 4, 7, 4, 2);
    for (int i = 0; i < 20; i++) begin
      stim_req = (i == 0) || (i == 11);
      enable = !(i inside {[9:12]});
      tick();
      obs = {stim_out, blank_out, busy, state_out, pulse_count, missed_count};
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL enable_model t=%0d got=%h expected=%h", i, obs, exp_v); end
      if (i == 9) begin
        n_checks++;
        if ({stim_out, blank_out, state_out, pulse_count} !== {1'b0, 1'b0, 3'd0, 8'd2}) begin
          n_fail++;
          $display("FAIL enable_drop t=%0d got stim=%b blank=%b state=%0d pc=%0d expected 0/0/0/2", i, stim_out, blank_out, state_out, pulse_count);
        end
      end
      if (i == 12) begin
        n_checks++;
        if ({busy, missed_count} !== 17'd0) begin n_fail++; $display("FAIL enable_low_req_ignored got busy=%b missed=%0d", busy, missed_count); end
      end
    end
    enable = 1'b1; stim_req = 1'b0;
  endtask

  task automatic test_reset_saturated();
    do_reset();
    set_cfg(100, 1, 2, 1, 65535);
    for (int i = 0; i < 65613; i++) begin
      stim_req = (i <= 65600);
      reset = (i == 65610);
      tick();
      obs = {stim_out, blank_out, busy, state_out, pulse_count, missed_count};
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL saturate_model t=%0d got=%h expected=%h", i, obs, exp_v); end
      if (i == 65609) begin
        n_checks++;
        if ({state_out, missed_count} !== {3'd4, 16'hFFFF}) begin n_fail++; $display("FAIL missed_saturated got state=%0d missed=%h expected 4/ffff", state_out, missed_count); end
      end
      if (i == 65610) begin
        n_checks++;
        if (obs !== 30'd0) begin n_fail++; $display("FAIL reset_mid_refract got=%h expected=0", obs); end
      end
    end
    reset = 1'b0; stim_req = 1'b0;
  endtask

  task automatic test_npulse_zero();
    do_reset();
    set_cfg(0, 1, 2, 1, 0);
    for (int i = 0; i < 7; i++) begin
      stim_req = (i inside {0, 1, 3});
      if (i == 3) npulse_cfg = 8'd0;
      tick();
      obs = {stim_out, blank_out, busy, state_out, pulse_count, missed_count};
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL npulse0_model t=%0d got=%h expected=%h", i, obs, exp_v); end
      if (i >= 3) begin
        n_checks++;
        if ({busy, state_out, missed_count} !== {1'b0, 3'd0, 16'd1}) begin
          n_fail++;
          $display("FAIL npulse0_idle t=%0d got busy=%b state=%0d missed=%0d expected 0/0/1", i, busy, state_out, missed_count);
        end
      end
    end
    stim_req = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    set_cfg(2, 2, 4, 2, 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_cfg($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 9),
                $urandom_range(0, 4), $urandom_range(0, 4));
      stim_req = ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 39) != 0);
      tick();
      obs = {stim_out, blank_out, busy, state_out, pulse_count, missed_count};
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random_model t=%0d got=%h expected=%h", i, obs, exp_v); end
    end
    enable = 1'b1; stim_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_train();
    test_clamp_missed();
    test_cfg_change();
    test_enable_drop();
    test_npulse_zero();
    test_random();
    test_reset_saturated();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
